// File: rtl/alu_issue_stage_if.sv
// ID/EX boundary bundle: ID-stage inputs, forwarding sources and the
// registered ALU-facing outputs of the issue stage.
interface alu_issue_stage_if;
  // ID-stage control
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [1:0]  aluOp;
  logic [5:0]  funct;
  logic        aluSrc;
  // ID-stage operands
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  // Forwarding sources
  logic        exmem_regWrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_res;
  logic        memwb_regWrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_res;
  // Registered outputs toward the ALU
  logic        ex_valid;
  logic [3:0]  aluCtr;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] store_data;
  logic        illegal;

  modport master (
    output in_valid, stall, flush, aluOp, funct, aluSrc,
           rs_addr, rt_addr, rs_data, rt_data, imm_ext,
           exmem_regWrite, exmem_rd, exmem_res,
           memwb_regWrite, memwb_rd, memwb_res,
    input  ex_valid, aluCtr, input1, input2, store_data, illegal
  );

  modport slave (
    input  in_valid, stall, flush, aluOp, funct, aluSrc,
           rs_addr, rt_addr, rs_data, rt_data, imm_ext,
           exmem_regWrite, exmem_rd, exmem_res,
           memwb_regWrite, memwb_rd, memwb_res,
    output ex_valid, aluCtr, input1, input2, store_data, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes aluOp/funct into aluCtr, resolves EX/MEM and
// MEM/WB forwarding, picks register or immediate for operand 2, and holds
// the result in the ID/EX register with stall and flush control.
module alu_issue_stage (
  input logic              clk,
  input logic              reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [3:0] CTR_ADD = 4'b0010;
  localparam logic [3:0] CTR_SUB = 4'b0110;
  localparam logic [3:0] CTR_AND = 4'b0000;
  localparam logic [3:0] CTR_OR  = 4'b0001;
  localparam logic [3:0] CTR_NOR = 4'b1100;
  localparam logic [3:0] CTR_SLT = 4'b0111;
  localparam logic [3:0] CTR_BNE = 4'b1111;

  logic [3:0]  aluCtrDec;
  logic        illegalDec;
  logic [31:0] rsFwd;
  logic [31:0] rtFwd;

  logic        exValid_q,   exValid_d;
  logic [3:0]  aluCtr_q,    aluCtr_d;
  logic [31:0] input1_q,    input1_d;
  logic [31:0] input2_q,    input2_d;
  logic [31:0] storeData_q, storeData_d;
  logic        illegal_q,   illegal_d;

  // Youngest in-flight writer wins; r0 is hardwired zero and never forwarded.
  function automatic logic [31:0] forwardOperand(
    input logic [4:0]  addr,
    input logic [31:0] rfData,
    input logic        exW,
    input logic [4:0]  exRd,
    input logic [31:0] exRes,
    input logic        wbW,
    input logic [4:0]  wbRd,
    input logic [31:0] wbRes
  );
    logic [31:0] value;
    value = rfData;
    if (exW && (exRd != 5'd0) && (exRd == addr)) begin
      value = exRes;
    end else if (wbW && (wbRd != 5'd0) && (wbRd == addr)) begin
      value = wbRes;
    end
    return value;
  endfunction

  // Translate aluOp/funct into the ALU control code and flag unknown R-type functs.
  always_comb begin
    aluCtrDec  = CTR_ADD;
    illegalDec = 1'b0;
    case (bus.aluOp)
      2'b00: aluCtrDec = CTR_ADD;
      2'b01: aluCtrDec = CTR_SUB;
      2'b11: aluCtrDec = CTR_BNE;
      default: begin
        case (bus.funct)
          6'b100000, 6'b100001: aluCtrDec = CTR_ADD;
          6'b100010, 6'b100011: aluCtrDec = CTR_SUB;
          6'b100100:            aluCtrDec = CTR_AND;
          6'b100101:            aluCtrDec = CTR_OR;
          6'b100111:            aluCtrDec = CTR_NOR;
          6'b101010, 6'b101011: aluCtrDec = CTR_SLT;
          default: begin
            aluCtrDec  = CTR_ADD;
            illegalDec = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Resolve forwarded values for both source registers.
  always_comb begin
    rsFwd = forwardOperand(bus.rs_addr, bus.rs_data,
                           bus.exmem_regWrite, bus.exmem_rd, bus.exmem_res,
                           bus.memwb_regWrite, bus.memwb_rd, bus.memwb_res);
    rtFwd = forwardOperand(bus.rt_addr, bus.rt_data,
                           bus.exmem_regWrite, bus.exmem_rd, bus.exmem_res,
                           bus.memwb_regWrite, bus.memwb_rd, bus.memwb_res);
  end

  // Next ID/EX contents: flush beats stall, stall holds, otherwise load.
  always_comb begin
    exValid_d   = exValid_q;
    aluCtr_d    = aluCtr_q;
    input1_d    = input1_q;
    input2_d    = input2_q;
    storeData_d = storeData_q;
    illegal_d   = illegal_q;
    if (bus.flush) begin
      exValid_d   = 1'b0;
      aluCtr_d    = CTR_ADD;
      input1_d    = 32'd0;
      input2_d    = 32'd0;
      storeData_d = 32'd0;
      illegal_d   = 1'b0;
    end else if (!bus.stall) begin
      exValid_d   = bus.in_valid;
      aluCtr_d    = aluCtrDec;
      input1_d    = rsFwd;
      input2_d    = bus.aluSrc ? bus.imm_ext : rtFwd;
      storeData_d = rtFwd;
      illegal_d   = bus.in_valid & illegalDec;
    end
  end

  // ID/EX pipeline register with asynchronous reset to a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exValid_q   <= 1'b0;
      aluCtr_q    <= CTR_ADD;
      input1_q    <= 32'd0;
      input2_q    <= 32'd0;
      storeData_q <= 32'd0;
      illegal_q   <= 1'b0;
    end else begin
      exValid_q   <= exValid_d;
      aluCtr_q    <= aluCtr_d;
      input1_q    <= input1_d;
      input2_q    <= input2_d;
      storeData_q <= storeData_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.ex_valid   = exValid_q;
  assign bus.aluCtr     = aluCtr_q;
  assign bus.input1     = input1_q;
  assign bus.input2     = input2_q;
  assign bus.store_data = storeData_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a vector table for decode/forwarding
// plus hand sequences for reset, stall hold, flush and async reset.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        inValid;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic        aluSrc;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic        exW;
    logic [4:0]  exRd;
    logic [31:0] exRes;
    logic        wbW;
    logic [4:0]  wbRd;
    logic [31:0] wbRes;
    logic        expValid;
    logic [3:0]  expCtr;
    logic [31:0] expIn1;
    logic [31:0] expIn2;
    logic [31:0] expStore;
    logic        expIll;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  alu_issue_stage_if bus();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    bus.in_valid       = v.inValid;
    bus.aluOp          = v.aluOp;
    bus.funct          = v.funct;
    bus.aluSrc         = v.aluSrc;
    bus.rs_addr        = v.rsAddr;
    bus.rt_addr        = v.rtAddr;
    bus.rs_data        = v.rsData;
    bus.rt_data        = v.rtData;
    bus.imm_ext        = v.imm;
    bus.exmem_regWrite = v.exW;
    bus.exmem_rd       = v.exRd;
    bus.exmem_res      = v.exRes;
    bus.memwb_regWrite = v.wbW;
    bus.memwb_rd       = v.wbRd;
    bus.memwb_res      = v.wbRes;
  endtask

  task automatic compareField(input string tag, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h", tag, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eValid,
                             input logic [3:0] eCtr, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] eStore,
                             input logic eIll);
    compareField(tag, "ex_valid",   {31'd0, bus.ex_valid}, {31'd0, eValid});
    compareField(tag, "aluCtr",     {28'd0, bus.aluCtr},   {28'd0, eCtr});
    compareField(tag, "input1",     bus.input1,            e1);
    compareField(tag, "input2",     bus.input2,            e2);
    compareField(tag, "store_data", bus.store_data,        eStore);
    compareField(tag, "illegal",    {31'd0, bus.illegal},  {31'd0, eIll});
  endtask

  function automatic vec_t mkR(input logic [5:0] f, input logic [3:0] ctr);
    vec_t v;
    v = '0;
    v.inValid = 1'b1; v.aluOp = 2'b10; v.funct = f;
    v.rsAddr = 5'd1; v.rtAddr = 5'd2; v.rsData = 32'h1; v.rtData = 32'h2;
    v.expValid = 1'b1; v.expCtr = ctr;
    v.expIn1 = 32'h1; v.expIn2 = 32'h2; v.expStore = 32'h2;
    return v;
  endfunction

  task automatic buildTable();
    vec_t v;
    // NOR with plain register operands
    v = mkR(6'b100111, 4'b1100);
    v.rsData = 32'h0F0F0000; v.rtData = 32'h00FF00FF;
    v.expIn1 = 32'h0F0F0000; v.expIn2 = 32'h00FF00FF; v.expStore = 32'h00FF00FF;
    vecs.push_back(v);
    // EX/MEM beats MEM/WB on rs
    v = '0;
    v.inValid = 1; v.aluOp = 2'b00; v.rsAddr = 3; v.rtAddr = 5;
    v.rsData = 32'h33; v.rtData = 32'h55;
    v.exW = 1; v.exRd = 3; v.exRes = 32'h11; v.wbW = 1; v.wbRd = 3; v.wbRes = 32'h22;
    v.expValid = 1; v.expCtr = 4'b0010; v.expIn1 = 32'h11; v.expIn2 = 32'h55; v.expStore = 32'h55;
    vecs.push_back(v);
    // EX/MEM write dropped: MEM/WB now supplies rs
    v.exW = 0; v.expIn1 = 32'h22;
    vecs.push_back(v);
    // r0 is never forwarded
    v = '0;
    v.inValid = 1; v.exW = 1; v.exRd = 0; v.exRes = 32'hDEAD;
    v.wbW = 1; v.wbRd = 0; v.wbRes = 32'hBEEF;
    v.expValid = 1; v.expCtr = 4'b0010;
    vecs.push_back(v);
    // unknown funct is illegal and decodes as add
    v = mkR(6'b000000, 4'b0010); v.expIll = 1; vecs.push_back(v);
    // bne ignores funct and never flags illegal
    v = mkR(6'b000000, 4'b1111); v.aluOp = 2'b11; vecs.push_back(v);
    // sub with rt forwarded from MEM/WB
    v = mkR(6'b100010, 4'b0110);
    v.rsAddr = 8; v.rsData = 32'h80; v.rtAddr = 7; v.rtData = 32'h70;
    v.wbW = 1; v.wbRd = 7; v.wbRes = 32'h77;
    v.expIn1 = 32'h80; v.expIn2 = 32'h77; v.expStore = 32'h77;
    vecs.push_back(v);
    vecs.push_back(mkR(6'b100100, 4'b0000));
    vecs.push_back(mkR(6'b100101, 4'b0001));
    vecs.push_back(mkR(6'b101010, 4'b0111));
    vecs.push_back(mkR(6'b101011, 4'b0111));
    vecs.push_back(mkR(6'b100001, 4'b0010));
    vecs.push_back(mkR(6'b100011, 4'b0110));
    vecs.push_back(mkR(6'b100000, 4'b0010));
    // beq: subtract, funct ignored
    v = mkR(6'b100111, 4'b0110); v.aluOp = 2'b01; vecs.push_back(v);
    // not-valid load: payload taken, ex_valid and illegal low
    v = mkR(6'b111111, 4'b0010); v.inValid = 0; v.expValid = 0; vecs.push_back(v);
    // immediate operand 2, store_data still the forwarded rt
    v = '0;
    v.inValid = 1; v.aluSrc = 1; v.imm = 32'h1234; v.rsAddr = 9; v.rtAddr = 9;
    v.rsData = 32'h90; v.rtData = 32'h90; v.exW = 1; v.exRd = 9; v.exRes = 32'h99;
    v.expValid = 1; v.expCtr = 4'b0010; v.expIn1 = 32'h99; v.expIn2 = 32'h1234; v.expStore = 32'h99;
    vecs.push_back(v);
    // rs from MEM/WB, rt from EX/MEM at the same time
    v = mkR(6'b100111, 4'b1100);
    v.rsAddr = 10; v.rsData = 32'hA0; v.rtAddr = 11; v.rtData = 32'hB0;
    v.exW = 1; v.exRd = 11; v.exRes = 32'hBB; v.wbW = 1; v.wbRd = 10; v.wbRes = 32'hAA;
    v.expIn1 = 32'hAA; v.expIn2 = 32'hBB; v.expStore = 32'hBB;
    vecs.push_back(v);
  endtask

  // Main test sequence.
  initial begin
    vec_t v;
    vec_t loadVec;
    checks = 0;
    errors = 0;
    buildTable();

    // Reset with random inputs on the bus
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    v = '0;
    v.inValid = 1'($urandom); v.aluOp = 2'($urandom); v.funct = 6'($urandom);
    v.aluSrc = 1'($urandom); v.rsAddr = 5'($urandom); v.rtAddr = 5'($urandom);
    v.rsData = $urandom; v.rtData = $urandom; v.imm = $urandom;
    v.exW = 1; v.exRd = 5'($urandom); v.exRes = $urandom;
    v.wbW = 1; v.wbRd = 5'($urandom); v.wbRes = $urandom;
    applyStimulus(v);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 4'b0010, 32'd0, 32'd0, 32'd0, 1'b0);

    // Deassert mid-cycle; the table starts loading on the next edge
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCtr,
                  vecs[i].expIn1, vecs[i].expIn2, vecs[i].expStore, vecs[i].expIll);
    end

    // Load an addi-style instruction, then stall three cycles with changing inputs
    loadVec = '0;
    loadVec.inValid = 1; loadVec.aluSrc = 1; loadVec.imm = 32'hFFFFFFFC;
    loadVec.rsAddr = 4; loadVec.rsData = 32'h44; loadVec.rtAddr = 6; loadVec.rtData = 32'h66;
    @(negedge clk);
    applyStimulus(loadVec);
    @(posedge clk);
    #1;
    checkOutput("imm_load", 1'b1, 4'b0010, 32'h44, 32'hFFFFFFFC, 32'h66, 1'b0);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      v = mkR(6'(c), 4'b0000);
      v.exW = 1; v.exRd = 4; v.exRes = 32'hEEEE0000 + c;
      v.wbW = 1; v.wbRd = 6; v.wbRes = 32'h6666 + c;
      applyStimulus(v);
      bus.stall = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d", c), 1'b1, 4'b0010, 32'h44, 32'hFFFFFFFC, 32'h66, 1'b0);
    end

    // Stall and flush together: bubble
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("stall_flush", 1'b0, 4'b0010, 32'd0, 32'd0, 32'd0, 1'b0);

    // Release and reload the NOR vector
    @(negedge clk);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    applyStimulus(vecs[0]);
    @(posedge clk);
    #1;
    checkOutput("reload", 1'b1, 4'b1100, 32'h0F0F0000, 32'h00FF00FF, 32'h00FF00FF, 1'b0);

    // Asynchronous reset between edges clears outputs immediately
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 4'b0010, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[1]);
    @(posedge clk);
    #1;
    checkOutput("after_reset", 1'b1, 4'b0010, 32'h11, 32'h55, 32'h55, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
